// File: rtl/ysyx_25030093_pkg.sv
// Shared types and defaults for the ysyx_25030093 instruction-fetch unit.
package ysyx_25030093_pkg;

  localparam int          XLEN_DEFAULT         = 32;
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    IFU_BOOT   = 2'd0,
    IFU_RUN    = 2'd1,
    IFU_HALTED = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [31:0]             inst;
    logic [XLEN_DEFAULT-1:0] pc;
    logic                    err;
  } fifo_entry_t;

endpackage

// File: rtl/ysyx_25030093_sync_fifo.sv
// Synchronous FIFO with flush; head is presented combinationally.
module ysyx_25030093_sync_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 65,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // pointer and occupancy next-state; flush wins over push/pop
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      wr_d  = push_i ? wr_q + AW'(1) : wr_q;
      rd_d  = pop_i  ? rd_q + AW'(1) : rd_q;
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // pointer and count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // storage write
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/ysyx_25030093_ifu_pf.sv
// Prefetching IFU: credit-limited sequential fetch into a FIFO, with redirect
// flush and dropping of in-flight stale responses.
module ysyx_25030093_ifu_pf
  import ysyx_25030093_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [31:0]     mem_rsp_data,
  input  logic            mem_rsp_err,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_err,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            busy
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = $bits(fifo_entry_t);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d, redir_pc_s;
  logic            pend_q, pend_d, stale_q, stale_d;
  logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d, fifo_cnt_s;
  logic [CW:0]     credit_s;
  logic            issue_s, accept_s, rsp_s, keep_s, pop_s;
  fifo_entry_t     push_entry_s, head_entry_s;
  logic [EW-1:0]   head_bits_s;

  assign credit_s   = {1'b0, outst_q} + {1'b0, fifo_cnt_s};
  assign issue_s    = (state_q == IFU_RUN) & ~halt & ~redirect_valid &
                      (credit_s < (CW+1)'(DEPTH));
  // a request that was not accepted stays up, even if halted or redirected
  assign mem_req_valid = pend_q | issue_s;
  assign mem_req_addr  = pend_q ? pend_addr_q : fetch_pc_q;
  assign accept_s   = mem_req_valid & mem_req_ready;
  assign rsp_s      = mem_rsp_valid & (outst_q != '0);
  assign keep_s     = rsp_s & (drop_q == '0) & ~redirect_valid;
  assign inst_valid = (fifo_cnt_s != '0);
  assign pop_s      = inst_valid & inst_ready;
  assign redir_pc_s = {redirect_pc[XLEN-1:2], 2'b00};
  assign busy       = (outst_q != '0) | (fifo_cnt_s != '0) | mem_req_valid;

  // next-state for FSM, fetch/response pcs and outstanding/drop counters
  always_comb begin
    state_d     = state_q;
    pend_d      = mem_req_valid & ~mem_req_ready;
    pend_addr_d = mem_req_addr;
    outst_d     = outst_q + CW'(accept_s) - CW'(rsp_s);
    drop_d      = (rsp_s && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    fetch_pc_d  = (accept_s && !stale_q) ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    rsp_pc_d    = keep_s ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
    stale_d     = accept_s ? 1'b0 : stale_q;

    case (state_q)
      IFU_BOOT:   state_d = IFU_RUN;
      IFU_RUN:    state_d = (halt && !pend_d) ? IFU_HALTED : IFU_RUN;
      IFU_HALTED: state_d = halt ? IFU_HALTED : IFU_RUN;
      default:    state_d = IFU_BOOT;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = redir_pc_s;
      rsp_pc_d   = redir_pc_s;
      // everything in flight is stale, including a request still waiting
      drop_d     = (state_q != IFU_BOOT) ? outst_d + CW'(pend_d) : drop_d;
      stale_d    = (state_q != IFU_BOOT) ? pend_d : stale_d;
    end else begin
      stale_d    = stale_d;
    end
  end

  // state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IFU_BOOT;
      fetch_pc_q  <= RESET_VECTOR;
      rsp_pc_q    <= RESET_VECTOR;
      pend_addr_q <= RESET_VECTOR;
      pend_q      <= 1'b0;
      stale_q     <= 1'b0;
      outst_q     <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      pend_addr_q <= pend_addr_d;
      pend_q      <= pend_d;
      stale_q     <= stale_d;
      outst_q     <= outst_d;
      drop_q      <= drop_d;
    end
  end

  assign push_entry_s = '{inst: mem_rsp_data, pc: rsp_pc_q, err: mem_rsp_err};
  assign head_entry_s = head_bits_s;

  ysyx_25030093_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (keep_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .flush_i     (redirect_valid),
    .head_o      (head_bits_s),
    .count_o     (fifo_cnt_s)
  );

  assign inst     = head_entry_s.inst;
  assign inst_pc  = head_entry_s.pc;
  assign inst_err = head_entry_s.err;

endmodule

// File: tb/tb_ysyx_25030093_ifu_pf.sv
// Directed bench for the prefetching IFU: a cycle table for streaming and
// backpressure, plus hand-written redirect, halt, error and stall sequences.
module tb_ysyx_25030093_ifu_pf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid, mem_rsp_err;
  logic [31:0] mem_rsp_data;
  logic        inst_valid, inst_ready, inst_err;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid, halt, busy;
  logic [31:0] redirect_pc;

  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_pop  = 0;
  logic [31:0] exp_pc;
  logic [31:0] err_addr;
  logic        mem_en;
  logic [31:0] rq [$];

  always #5 clk = ~clk;

  ysyx_25030093_ifu_pf dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .mem_rsp_err    (mem_rsp_err),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_err       (inst_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .busy           (busy)
  );

  typedef struct {
    logic        ir;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
    logic        bsy;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock: score any pop, follow redirects in the model, then act as memory.
  task automatic step();
    logic        acc;
    logic [31:0] acc_a, a;
    #1;
    acc   = mem_req_valid && mem_req_ready;
    acc_a = mem_req_addr;
    if (inst_valid && inst_ready) begin
      chk("pop_pc", inst_pc, exp_pc);
      chk("pop_inst", inst, exp_pc);
      chk("pop_err", {31'd0, inst_err}, {31'd0, exp_pc == err_addr});
      n_pop++;
      exp_pc = exp_pc + 32'd4;
    end
    if (redirect_valid) exp_pc = redirect_pc & 32'hFFFF_FFFC;
    @(posedge clk);
    #1;
    if (acc) rq.push_back(acc_a);
    if (mem_en && rq.size() > 0) begin
      a = rq.pop_front();
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = a;
      mem_rsp_err   = (a == err_addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = 32'd0;
      mem_rsp_err   = 1'b0;
    end
    #1;
  endtask

  // Reset and leave the bench in the reset-release cycle (c0).
  task automatic do_reset();
    rst = 1'b1;
    rq.delete();
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; mem_rsp_err = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
    mem_req_ready = 1'b1; inst_ready = 1'b1; mem_en = 1'b1;
    err_addr = 32'd0;
    exp_pc = 32'h8000_0000;
    n_pop = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    //            ir    rv    addr          iv    pc            busy
    tbl[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0,       1'b1};
    tbl[2]  = '{1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0,       1'b1};
    tbl[3]  = '{1'b1, 1'b1, 32'h8000_0008, 1'b1, 32'h8000_0000, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 32'h8000_000C, 1'b1, 32'h8000_0004, 1'b1};
    tbl[5]  = '{1'b0, 1'b1, 32'h8000_0010, 1'b1, 32'h8000_0008, 1'b1};
    tbl[6]  = '{1'b0, 1'b1, 32'h8000_0014, 1'b1, 32'h8000_0008, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8000_0008, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8000_0008, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 32'h0,        1'b1, 32'h8000_0008, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 32'h0,        1'b1, 32'h8000_0008, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 32'h8000_0018, 1'b1, 32'h8000_000C, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 32'h8000_001C, 1'b1, 32'h8000_0010, 1'b1};
    tbl[13] = '{1'b1, 1'b1, 32'h8000_0020, 1'b1, 32'h8000_0014, 1'b1};
    tbl[14] = '{1'b1, 1'b1, 32'h8000_0024, 1'b1, 32'h8000_0018, 1'b1};
    tbl[15] = '{1'b1, 1'b1, 32'h8000_0028, 1'b1, 32'h8000_001C, 1'b1};

    // streaming, FIFO fill under IDU backpressure, and resume
    do_reset();
    for (int i = 0; i < 16; i++) begin
      inst_ready = tbl[i].ir;
      #1;
      chk($sformatf("tbl%0d_req_valid", i), {31'd0, mem_req_valid}, {31'd0, tbl[i].rv});
      if (tbl[i].rv) chk($sformatf("tbl%0d_req_addr", i), mem_req_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_inst_valid", i), {31'd0, inst_valid}, {31'd0, tbl[i].iv});
      if (tbl[i].iv) chk($sformatf("tbl%0d_inst_pc", i), inst_pc, tbl[i].pc);
      chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
      step();
    end

    // memory stalls the first request for 5 cycles
    do_reset();
    mem_req_ready = 1'b0;
    step();
    for (int i = 1; i <= 5; i++) begin
      #1;
      chk($sformatf("stall%0d_valid", i), {31'd0, mem_req_valid}, 32'd1);
      chk($sformatf("stall%0d_addr", i), mem_req_addr, 32'h8000_0000);
      step();
    end
    mem_req_ready = 1'b1;
    #1 chk("stall_accept_addr", mem_req_addr, 32'h8000_0000);
    step();
    #1 chk("stall_next_addr", mem_req_addr, 32'h8000_0004);
    repeat (4) step();
    chk("stall_pops", n_pop, 3);

    // redirect with 3 outstanding: three stale responses dropped
    do_reset();
    mem_en = 1'b0;
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1002;
    #1 chk("redir_no_issue", {31'd0, mem_req_valid}, 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("redir_new_addr", mem_req_addr, 32'h8000_1000);
    chk("redir_new_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("redir_fifo_empty", {31'd0, inst_valid}, 32'd0);
    mem_en = 1'b1;
    step();
    for (int i = 6; i <= 9; i++) begin
      #1 chk($sformatf("redir_c%0d_iv", i), {31'd0, inst_valid}, 32'd0);
      step();
    end
    #1;
    chk("redir_first_iv", {31'd0, inst_valid}, 32'd1);
    chk("redir_first_pc", inst_pc, 32'h8000_1000);
    step();

    // redirect in the same cycle as a pop and a response
    do_reset();
    repeat (5) step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
    #1;
    chk("rpr_no_issue", {31'd0, mem_req_valid}, 32'd0);
    chk("rpr_rsp_present", {31'd0, mem_rsp_valid}, 32'd1);
    chk("rpr_pop_pc", inst_pc, 32'h8000_0008);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("rpr_addr", mem_req_addr, 32'h8000_2000);
    chk("rpr_iv0", {31'd0, inst_valid}, 32'd0);
    step();
    #1 chk("rpr_iv1", {31'd0, inst_valid}, 32'd0);
    chk("rpr_pops", n_pop, 3);
    step();
    #1;
    chk("rpr_new_iv", {31'd0, inst_valid}, 32'd1);
    chk("rpr_new_pc", inst_pc, 32'h8000_2000);
    step();

    // halt mid-stream with an access fault on one word
    do_reset();
    err_addr = 32'h8000_0008;
    repeat (4) step();
    halt = 1'b1;
    #1 chk("halt_no_req_c4", {31'd0, mem_req_valid}, 32'd0);
    step();
    #1;
    chk("halt_no_req_c5", {31'd0, mem_req_valid}, 32'd0);
    chk("halt_err_pc", inst_pc, 32'h8000_0008);
    chk("halt_err_bit", {31'd0, inst_err}, 32'd1);
    step();
    #1;
    chk("halt_busy_low", {31'd0, busy}, 32'd0);
    chk("halt_no_req_c6", {31'd0, mem_req_valid}, 32'd0);
    step();
    halt = 1'b0;
    step();
    #1;
    chk("unhalt_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("unhalt_addr", mem_req_addr, 32'h8000_000C);
    step();

    // redirect while a request waits unaccepted: it goes out stale
    do_reset();
    mem_req_ready = 1'b0;
    step();
    #1 chk("pend_addr_c1", mem_req_addr, 32'h8000_0000);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_3000;
    #1;
    chk("pend_valid_c2", {31'd0, mem_req_valid}, 32'd1);
    chk("pend_addr_c2", mem_req_addr, 32'h8000_0000);
    step();
    redirect_valid = 1'b0;
    mem_req_ready = 1'b1;
    #1 chk("pend_addr_c3", mem_req_addr, 32'h8000_0000);
    step();
    #1 chk("pend_new_addr", mem_req_addr, 32'h8000_3000);
    step();
    #1 chk("pend_c5_iv", {31'd0, inst_valid}, 32'd0);
    step();
    #1;
    chk("pend_new_iv", {31'd0, inst_valid}, 32'd1);
    chk("pend_new_pc", inst_pc, 32'h8000_3000);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25030093_ifu_pf.md
Name: ysyx_25030093_ifu_pf

Overview:
Parametrised instruction-fetch unit replacing the fixed pc-register/direct-inst path of the single-cycle top. It issues sequential fetch requests over a valid/ready memory port, buffers returned instructions in a DEPTH-entry prefetch FIFO and presents them to decode over a valid/ready handshake. Branch/jump redirects from EXU flush the buffer and discard in-flight stale responses.

Parameters:
XLEN, 32, address/data width (32 only for RV32; parameter kept for width-generic signals)
DEPTH, 4, prefetch FIFO entries and max outstanding requests (power of 2, >=2)
RESET_VECTOR, 32'h8000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset; asynchronous, active-high
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  fetch address, word aligned
mem_rsp_valid  in  1  response valid (in order, always accepted)
mem_rsp_data  in  32  instruction word
mem_rsp_err  in  1  access fault for this response
inst_valid  out  1  FIFO head valid to IDU
inst_ready  in  1  IDU consumes head
inst  out  32  head instruction
inst_pc  out  XLEN  pc of head instruction
inst_err  out  1  head carries access fault
redirect_valid  in  1  flush and refetch
redirect_pc  in  XLEN  new fetch pc; bits [1:0] ignored (treated 0)
halt  in  1  level; stop issuing new requests (ebreak/trap)
busy  out  1  outstanding requests or FIFO non-empty

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_VECTOR, FIFO empty, outstanding=0, drop_cnt=0, mem_req_valid=0, inst_valid=0, busy=0, state=BOOT.
- FSM: BOOT -> RUN after one cycle (no request in reset-release cycle). RUN -> HALTED when halt=1 and no request pending. HALTED -> RUN when halt=0. redirect accepted in any state except BOOT (in BOOT it overrides fetch_pc, state still moves to RUN).
- Credit: request issued only if outstanding + fifo_count < DEPTH, state=RUN, halt=0. Counters width $clog2(DEPTH)+1.
- Request rule: once mem_req_valid=1, mem_req_addr held stable until mem_req_ready; valid not withdrawn (halt does not drop a pending request). On accept: outstanding++, fetch_pc += 4 (wraps mod 2^XLEN). Back-to-back requests allowed (one per cycle).
- Responses arrive in order, one per cycle max; each decrements outstanding. If drop_cnt>0: response discarded, drop_cnt--. Else pushed {data, pc, err}; pc taken from rsp_pc counter that advances by 4 per kept push.
- Response with mem_rsp_valid while outstanding=0: protocol error, ignored (assertion in bench).
- FIFO: combinational head on inst/inst_pc/inst_err; pop on inst_valid&inst_ready; simultaneous push+pop when full is legal since credit prevents overflow; push to empty FIFO visible next cycle (1-cycle response-to-decode latency).
- Redirect (cycle t): FIFO cleared (any pop that cycle is still a valid consumption); fetch_pc and rsp_pc <= redirect_pc&~3; drop_cnt <= outstanding after this cycle's accept/response updates, plus 1 if a request is pending-but-unaccepted (it becomes stale on accept and does not advance fetch_pc). A response in cycle t is dropped. First new request no earlier than t+1.
- Redirect while drop_cnt>0: drop counts accumulate correctly; never negative.
- inst_err entries are delivered normally; fetch continues sequentially (EXU decides trap).
- busy = (outstanding!=0)|(fifo_count!=0)|mem_req_valid.

Decomposition:
- Shared package ysyx_25030093_pkg: XLEN default, RESET_VECTOR, ifu state enum (BOOT/RUN/HALTED), fifo entry struct {inst, pc, err}.
- One sub-module: ysyx_25030093_sync_fifo (DEPTH, WIDTH; push/pop/flush/count, async reset).

Test Plan:
- Reset release, mem_req_ready=1, zero-latency-plus-1 memory returning addr as data -> requests 0x80000000,0x80000004,...; IDU sees inst_pc=inst, first inst_valid at cycle 3 after release.
- inst_ready=0 held -> exactly DEPTH=4 requests issued, then mem_req_valid=0; release ready -> 4 pops then streaming resumes at 0x80000010.
- mem_req_ready=0 for 5 cycles -> mem_req_addr stable at 0x80000000, no duplicate request.
- 3 outstanding, redirect_pc=0x80001002 -> next 3 responses dropped, next delivered inst_pc=0x80001000, FIFO empty cycle after redirect.
- Redirect same cycle as pop and response -> popped inst counted once, response dropped, no stale pc ever reaches IDU.
- halt=1 mid-stream -> no new requests, outstanding drain into FIFO, busy falls after last pop; rsp_err=1 on one word -> that entry inst_err=1, neighbours 0.
